// File: rtl/conv_mac_sequencer.sv
// rtl/conv_mac_sequencer.sv - one shared 8x8 sign-magnitude multiplier walked across a KERNEL_N-tap window
// Optional CONV_RELU_EN: clamps negative window sums to zero in DRAIN.
module conv_mac_sequencer #(
   parameter int KERNEL_N = 9,
   parameter int ACC_W    = 20
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  w_we,
   input  logic [3:0]            w_addr,
   input  logic [7:0]            w_data,
   input  logic                  win_valid,
   output logic                  win_ready,
   input  logic [KERNEL_N*8-1:0] win_data,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ACC_W-1:0]      res_data,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

   state_t                state;
   logic [7:0]            w_stg [KERNEL_N];
   logic [7:0]            w_act [KERNEL_N];
   logic [KERNEL_N*8-1:0] pix_q;
   logic [3:0]            idx;
   logic signed [15:0]    p_reg;
   logic                  p_vld;
   logic [ACC_W-1:0]      acc;

   logic                  win_hs;
   logic                  w_wr_ok;
   logic [7:0]            pix_sel;
   logic [7:0]            w_sel;
   logic signed [15:0]    prod;
   logic [ACC_W-1:0]      sum;
   logic [ACC_W-1:0]      drain_sum;

   // -128 has no sign-magnitude encoding, so it folds onto -127
   function automatic logic signed [7:0] sm_clamp(input logic [7:0] v);
      return (v == 8'h80) ? 8'sh81 : signed'(v);
   endfunction

   assign win_hs  = win_valid && win_ready;
   assign w_wr_ok = w_we && ({1'b0, w_addr} < 5'(KERNEL_N));
   assign pix_sel = pix_q[{idx, 3'b000} +: 8];
   assign w_sel   = w_act[idx];
   assign prod    = sm_clamp(pix_sel) * sm_clamp(w_sel);
   assign sum     = acc + {{(ACC_W-16){p_reg[15]}}, p_reg};

`ifdef CONV_RELU_EN
   assign drain_sum = sum[ACC_W-1] ? '0 : sum;
`else
   assign drain_sum = sum;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         win_ready <= 1'b1;
         res_valid <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
         pix_q     <= '0;
         idx       <= '0;
         p_reg     <= '0;
         p_vld     <= 1'b0;
         acc       <= '0;
         for (int k = 0; k < KERNEL_N; k++) begin
            w_stg[k] <= '0;
            w_act[k] <= '0;
         end
      end else begin
         for (int k = 0; k < KERNEL_N; k++) begin
            if (w_wr_ok && (w_addr == 4'(k)))
               w_stg[k] <= w_data;
         end

         case (state)
            IDLE: begin
               if (win_hs) begin
                  // bank swap sees a write landing on the same edge
                  for (int k = 0; k < KERNEL_N; k++)
                     w_act[k] <= (w_wr_ok && (w_addr == 4'(k))) ? w_data : w_stg[k];
                  pix_q     <= win_data;
                  acc       <= '0;
                  idx       <= '0;
                  p_vld     <= 1'b0;
                  win_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= MAC;
               end
            end
            MAC: begin
               p_reg <= prod;
               p_vld <= 1'b1;
               if (p_vld)
                  acc <= sum;
               idx <= idx + 4'd1;
               if (idx == 4'(KERNEL_N-1))
                  state <= DRAIN;
            end
            DRAIN: begin
               acc   <= drain_sum;
               p_vld <= 1'b0;
               state <= OUT;
            end
            OUT: begin
               if (!res_valid) begin
                  res_valid <= 1'b1;
                  res_data  <= acc;
               end else if (res_ready) begin
                  res_valid <= 1'b0;
                  win_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb/tb_conv_mac_sequencer.sv - scoreboard bench for conv_mac_sequencer
module tb_conv_mac_sequencer;
   localparam int N  = 9;
   localparam int AW = 20;

   logic           sys_clk = 1'b0;
   logic           sys_rst_n;
   logic           w_we;
   logic [3:0]     w_addr;
   logic [7:0]     w_data;
   logic           win_valid;
   logic           win_ready;
   logic [N*8-1:0] win_data;
   logic           res_valid;
   logic           res_ready;
   logic [AW-1:0]  res_data;
   logic           busy;

   conv_mac_sequencer #(.KERNEL_N(N), .ACC_W(AW)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   int t_acc = 0;
   logic signed [7:0] m_stg [N];
   logic signed [7:0] m_act [N];
   logic signed [7:0] px [N];
   logic [AW-1:0]     sb [$];
   logic [AW-1:0]     held;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int sm(input logic signed [7:0] v);
      return (v == -8'sd128) ? -127 : int'(v);
   endfunction

   function automatic logic [AW-1:0] model(input logic signed [7:0] p [N]);
      int s = 0;
      for (int k = 0; k < N; k++) s += sm(p[k]) * sm(m_act[k]);
`ifdef CONV_RELU_EN
      if (s < 0) s = 0;
`endif
      return AW'(s);
   endfunction

   task automatic wr(input int a, input logic signed [7:0] d);
      @(negedge sys_clk);
      w_we = 1'b1; w_addr = 4'(a); w_data = d;
      @(posedge sys_clk);
      if (a < N) m_stg[a] = d;
      #1 w_we = 1'b0;
   endtask

   task automatic set_all(input logic signed [7:0] d);
      for (int k = 0; k < N; k++) wr(k, d);
   endtask

   task automatic accept_model();
      for (int k = 0; k < N; k++) m_act[k] = m_stg[k];
      sb.push_back(model(px));
   endtask

   task automatic pack();
      for (int k = 0; k < N; k++) win_data[8*k +: 8] = px[k];
   endtask

   task automatic send();
      int i;
      @(negedge sys_clk);
      pack();
      win_valid = 1'b1;
      for (i = 0; i < 50 && !win_ready; i++) @(negedge sys_clk);
      if (!win_ready) begin
         chk("accept_timeout", 0, 1);
         win_valid = 1'b0;
         return;
      end
      @(posedge sys_clk);
      #1;
      t_acc = cyc;
      win_valid = 1'b0;
      accept_model();
      chk("acc_busy", 32'(busy), 1);
      chk("acc_win_ready", 32'(win_ready), 0);
   endtask

   task automatic wait_valid(input int lat);
      int i;
      for (i = 0; i < 40; i++) begin
         @(posedge sys_clk);
         #1;
         if (res_valid) break;
      end
      if (!res_valid) begin
         chk("res_timeout", 0, 1);
         return;
      end
      if (lat > 0) chk("latency", 32'(cyc - t_acc), 32'(lat));
   endtask

   task automatic take(input string tag);
      logic [AW-1:0] e;
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      chk(tag, 32'(res_data), 32'(e));
      if (res_ready) begin
         @(posedge sys_clk);
         #1 chk({tag, "_pulse"}, 32'(res_valid), 0);
      end
   endtask

   initial begin
      sys_rst_n = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
      win_valid = 1'b0; win_data = '0; res_ready = 1'b1;
      for (int k = 0; k < N; k++) begin m_stg[k] = 0; m_act[k] = 0; end
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_win_ready", 32'(win_ready), 1);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_data", 32'(res_data), 0);
      chk("rst_busy", 32'(busy), 0);
      @(negedge sys_clk) sys_rst_n = 1'b1;

      // ramp pixels against unit weights; out-of-range address must be ignored
      set_all(8'sd1);
      wr(9, 8'sd50);
      for (int k = 0; k < N; k++) px[k] = 8'(k + 1);
      send(); wait_valid(N + 2); take("t1_sum45");

      set_all(-8'sd1);
      for (int k = 0; k < N; k++) px[k] = 8'sd127;
      send(); wait_valid(N + 2); take("t2_neg");

      set_all(8'sd0);
      wr(0, 8'sd1);
      px[0] = -8'sd128;
      for (int k = 1; k < N; k++) px[k] = 8'sd5;
      send(); wait_valid(N + 2); take("t3_clamp");

      set_all(-8'sd128);
      for (int k = 0; k < N; k++) px[k] = -8'sd128;
      send(); wait_valid(N + 2); take("t3_clamp_all");

      // downstream stall with a competing window offered
      set_all(8'sd3);
      for (int k = 0; k < N; k++) px[k] = 8'(2 * k - 7);
      @(negedge sys_clk) res_ready = 1'b0;
      send(); wait_valid(N + 2);
      held = res_data;
      chk("t4_data", 32'(res_data), 32'(sb.pop_front()));
      for (int k = 0; k < N; k++) px[k] = 8'(k);
      @(negedge sys_clk);
      pack();
      win_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge sys_clk);
         #1;
         chk("t4_hold_valid", 32'(res_valid), 1);
         chk("t4_hold_data", 32'(res_data), 32'(held));
         chk("t4_hold_ready", 32'(win_ready), 0);
      end
      @(negedge sys_clk) res_ready = 1'b1;
      @(posedge sys_clk);
      #1;
      chk("t4_rel_valid", 32'(res_valid), 0);
      chk("t4_rel_ready", 32'(win_ready), 1);
      @(posedge sys_clk);
      #1;
      t_acc = cyc;
      chk("t4_taken", 32'(win_ready), 0);
      chk("t4_taken_busy", 32'(busy), 1);
      win_valid = 1'b0;
      accept_model();
      wait_valid(N + 2); take("t4_second");

      // restaging weights while a window is in flight
      set_all(8'sd1);
      for (int k = 0; k < N; k++) px[k] = 8'(k + 1);
      send();
      set_all(8'sd2);
      wait_valid(0); take("t5_a45");
      send(); wait_valid(N + 2); take("t5_b90");

      // reset in the middle of MAC
      set_all(8'sd3);
      send();
      repeat (4) @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("t6_win_ready", 32'(win_ready), 1);
      chk("t6_res_valid", 32'(res_valid), 0);
      chk("t6_res_data", 32'(res_data), 0);
      chk("t6_busy", 32'(busy), 0);
      void'(sb.pop_back());
      for (int k = 0; k < N; k++) m_stg[k] = 0;
      @(negedge sys_clk) sys_rst_n = 1'b1;
      send(); wait_valid(N + 2); take("t6_cleared");

      chk("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
